// File: rtl/mem_stream_reader.sv
// Burst read controller: sweeps an address range on a registered-read memory and
// presents the returned words as a valid/ready stream through a 2-entry buffer.
module mem_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   beat_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  vld_p1;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            occupancy;
    logic                  pop;
    logic                  accept;
    logic                  last_hs;
    logic [2:0]            credit_use;
    logic [2:0]            credit_lim;

    assign pop        = m_valid && m_ready;
    assign accept     = (state == IDLE) && start;
    assign last_hs    = pop && m_last;
    assign credit_use = {1'b0, occupancy} + {2'b00, vld_p1};
    assign credit_lim = 3'd2 + {2'b00, pop};

    assign busy             = (state != IDLE);
    assign done             = done_q;
    assign mem_read_address = mem_read_en ? addr_q : last_addr_q;
    assign m_valid          = (occupancy != 2'd0);
    assign m_data           = fifo_mem[rd_ptr];
    assign m_last           = m_valid && (beat_cnt == (ADDR_WIDTH+1)'(1));

    // A read may only be issued if the buffer can still hold it once every
    // outstanding read has landed; a pop this cycle frees a slot immediately.
    always_comb begin
        mem_read_en = 1'b0;
        if ((state == RUN) && (issue_cnt != '0) && (credit_use < credit_lim)) begin
            mem_read_en = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (length != '0)) state_nxt = RUN;
            end
            RUN: begin
                if (last_hs) begin
                    state_nxt = IDLE;
                end else if (mem_read_en && (issue_cnt == (ADDR_WIDTH+1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: issue side (state, counters, address).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            beat_cnt    <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (accept && (length == '0)) || last_hs;
            if (accept) begin
                issue_cnt <= length;
                beat_cnt  <= length;
                addr_q    <= base_addr;
            end else begin
                if (mem_read_en) begin
                    issue_cnt   <= issue_cnt - 1'b1;
                    addr_q      <= addr_q + 1'b1;
                    last_addr_q <= addr_q;
                end
                if (pop) beat_cnt <= beat_cnt - 1'b1;
            end
        end
    end

    // Stage p1: memory return captured into the output buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            occupancy   <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            vld_p1 <= mem_read_en;
            if (vld_p1) begin
                fifo_mem[wr_ptr] <= mem_data_out;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({vld_p1, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed + randomized bench for mem_stream_reader with a queue-based reference
// model of the expected address and data streams.
module tb_mem_stream_reader;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy, done, mem_read_en;
    logic [AW-1:0] mem_read_address;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .mem_read_en(mem_read_en),
        .mem_read_address(mem_read_address), .mem_data_out(mem_data_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (mem_read_en) mem_data_out <= mem[mem_read_address];

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_addr_q[$];
    int            out_cnt  = 0;
    int            done_cnt = 0;
    int            hs_total = 0;
    int            bursts   = 0;
    bit            rdy_rand = 0;
    logic          prev_v = 0, prev_r = 0;
    logic [DW-1:0] prev_d = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer and scoreboard: drive ready, then judge the cycle.
    always begin
        @(negedge clk);
        m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (rst) begin
            prev_v  = 0;
            out_cnt = 0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("stall_valid_held", m_valid, 1);
                chk("stall_data_stable", m_data, prev_d);
            end
            if (mem_read_en) begin
                if (exp_addr_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("read_addr", mem_read_address, exp_addr_q.pop_front());
                out_cnt++;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
                else begin
                    chk("last_flag", m_last, exp_q.size() == 1);
                    if (m_ready) chk("beat_data", m_data, exp_q.pop_front());
                end
            end
            if (m_valid && m_ready) begin
                out_cnt--;
                hs_total++;
            end
            chk("credit_bound", out_cnt <= 2, 1);
            if (done) done_cnt++;
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
        end
    end

    task automatic load_expect(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back((b + i) % DEPTH);
            exp_q.push_back(mem[(b + i) % DEPTH]);
        end
    endtask

    // Runs one burst; optionally pokes a second start at cycle 'poke' of the wait.
    task automatic burst(input int b, input int n, input int poke);
        int t;
        load_expect(b, n);
        bursts++;
        @(negedge clk);
        start = 1; base_addr = AW'(b); length = (AW+1)'(n);
        @(negedge clk);
        start = 0;
        #2;
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            start = (t == poke);
            base_addr = AW'(b + 7);
            length = (AW+1)'(3);
            #2;
            t++;
        end
        start = 0;
        chk("done_seen", done, 1);
        chk("busy_low_in_done", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_count", done_cnt, bursts);
    endtask

    initial begin
        rst = 1; start = 0; base_addr = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(32'h100 + i);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_read_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        @(negedge clk);
        rst = 0;

        // Basic burst with exact cycle timing.
        load_expect(4, 4);
        bursts++;
        @(negedge clk);
        start = 1; base_addr = 5'd4; length = 6'd4;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 0;
            #2;
            chk($sformatf("basic_busy_c%0d", k), busy, (k <= 6));
            chk($sformatf("basic_done_c%0d", k), done, (k == 7));
            chk($sformatf("basic_valid_c%0d", k), m_valid, (k >= 3 && k <= 6));
            chk($sformatf("basic_last_c%0d", k), m_last, (k == 6));
            chk($sformatf("basic_rden_c%0d", k), mem_read_en, (k <= 4));
            if (k >= 3 && k <= 6) chk($sformatf("basic_data_c%0d", k), m_data, 32'h100 + k + 1);
        end
        chk("basic_done_count", done_cnt, 1);

        burst(30, 4, -1);

        // Zero length: done in cycle 1, nothing else happens.
        bursts++;
        @(negedge clk);
        start = 1; base_addr = 5'd9; length = 6'd0;
        @(negedge clk);
        start = 0;
        #2;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_rden", mem_read_en, 0);
        chk("zero_valid", m_valid, 0);
        @(negedge clk);
        #2;
        chk("zero_done_once", done, 0);
        chk("zero_done_count", done_cnt, bursts);

        // Random memory and backpressure.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        rdy_rand = 1;
        burst(int'($urandom_range(0, DEPTH - 1)), 8, -1);
        burst(int'($urandom_range(0, DEPTH - 1)), 32, -1);
        for (int r = 0; r < 5; r++)
            burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 32)), -1);

        // Start while busy is ignored.
        burst(12, 8, 3);

        // Start accepted in the done cycle.
        load_expect(20, 3);
        bursts++;
        start = 1; base_addr = 5'd20; length = 6'd3;
        @(negedge clk);
        start = 0;
        #2;
        chk("done_cycle_start_busy", busy, 1);
        chk("done_cycle_start_rden", mem_read_en, 1);
        chk("done_cycle_start_addr", mem_read_address, 20);
        begin
            int t = 0;
            while (!done && t < 2000) begin @(negedge clk); #2; t++; end
        end
        chk("done_cycle_burst_done", done, 1);
        chk("done_cycle_burst_drained", exp_q.size(), 0);

        // Reset mid-burst after two beats.
        rdy_rand = 0;
        begin
            int h0, t;
            h0 = hs_total;
            load_expect(3, 8);
            @(negedge clk);
            start = 1; base_addr = 5'd3; length = 6'd8;
            @(negedge clk);
            start = 0;
            t = 0;
            while (hs_total - h0 < 2 && t < 200) begin @(negedge clk); #2; t++; end
            chk("mid_two_beats", hs_total - h0, 2);
        end
        rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_rden", mem_read_en, 0);
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_last", m_last, 0);
        chk("mid_rst_addr", mem_read_address, 0);
        chk("mid_rst_data", m_data, 0);
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        done_cnt = 0;
        bursts = 0;
        burst(0, 2, -1);

        repeat (3) @(negedge clk);
        #2;
        chk("final_no_extra_done", done_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stream_reader.md
# mem_stream_reader

Read-side controller for the single-clock registered-read memory in the dot-product datapath. On a start command it sweeps a contiguous address range, drives the memory read port, absorbs the memory's one-cycle read latency, and presents the words as a valid/ready stream with a last flag. Backpressure is fully honoured through a 2-entry output buffer, and full throughput of one word per cycle is sustained while the consumer accepts.

## Interface
- DATA_WIDTH, 32, word width; equals the memory's data width
- ADDR_WIDTH, 5, memory address width; burst lengths run from 0 to 2^ADDR_WIDTH words
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle burst request; ignored while busy is high
- base_addr  in  ADDR_WIDTH  first address, sampled with start
- length  in  ADDR_WIDTH+1  word count, sampled with start
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse when a burst completes
- mem_read_en  out  1  memory read enable
- mem_read_address  out  ADDR_WIDTH  memory read address
- mem_data_out  in  DATA_WIDTH  memory registered read data; valid the cycle after mem_read_en
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from consumer
- m_last  out  1  marks the final word of the burst; qualified by m_valid

## Operation
- FSM states:
  - IDLE: wait for start.
  - RUN: issue reads.
  - DRAIN: all reads issued; emptying the buffer.
- Transitions:
  - IDLE -> RUN on start with length > 0.
  - IDLE -> IDLE on start with length = 0; done pulses in the next cycle, and no reads or stream beats occur.
  - RUN -> DRAIN in the cycle after the final read is issued.
  - DRAIN -> IDLE on the handshake of the m_last beat.
  - A burst may end in RUN -> IDLE directly if the last issue and the last handshake coincide; they cannot coincide, so DRAIN is always visited for at least one cycle.
- Registers:
  - Issue counter: words remaining to issue.
  - Address register: starts at base_addr and increments by 1 per issue, wrapping modulo 2^ADDR_WIDTH (e.g. base 30, length 4 reads 30, 31, 0, 1).
  - Beat counter: words remaining to deliver. m_last is high when this counter equals 1 and m_valid is high.
- Read issue: mem_read_en is combinational. It is high in RUN when issue count > 0 and occupancy + inflight − pop < 2, where:
  - occupancy = buffer entries (0..2)
  - inflight = 1 if a read was issued in the previous cycle
  - pop = m_valid && m_ready
- mem_read_address equals the address register whenever mem_read_en is high, and holds its value otherwise.
- Capture: when inflight = 1, mem_data_out is pushed into the 2-entry FIFO at the end of that cycle. The credit rule guarantees no overflow.
- Stream:
  - m_data/m_valid reflect the FIFO head.
  - A handshake is m_valid && m_ready.
  - m_valid never drops without a handshake.
  - m_data is stable while m_valid is high and m_ready is low.
- busy is high from the cycle after accepted start through the cycle of the final handshake inclusive.
- start while busy is high is ignored: no effect on counters or addresses.

## Timing
- Reset values (asynchronous): state IDLE; busy, done, mem_read_en, m_valid, m_last = 0; mem_read_address, m_data = 0; all counters, FIFO pointers and inflight = 0.
- Start sampled at cycle 0:
  - cycle 1: busy = 1, first mem_read_en at base_addr
  - cycle 2: memory data valid
  - cycle 3: first m_valid
- With m_ready held high: one beat per cycle, so an N-word burst has its last handshake at cycle N+2 and done at cycle N+3.
- done is high exactly one cycle, the cycle after the final handshake, with busy = 0 in that cycle. A new start is accepted in the done cycle.
- Backpressure: while m_ready is low with 2 entries buffered, mem_read_en stays low. Issue resumes in the same cycle m_ready rises, via the pop term.
- Reset mid-burst:
  - All state clears immediately.
  - Memory data returning in the cycle after reset release is discarded, since inflight = 0.
  - No done pulse is produced.

## Test plan
- Basic burst: base 4, length 4, m_ready = 1, memory preloaded with mem[i] = 0x100+i -> m_data sequence 0x104..0x107 in cycles 3–6, m_last only on 0x107, done in cycle 7, busy high in cycles 1–6.
- Wrap-around: base 30, length 4 -> addresses 30, 31, 0, 1 issued; data matches those addresses in order.
- Backpressure: length 8, m_ready toggled pseudo-randomly -> no word lost or duplicated, m_data stable while stalled, mem_read_en never high when buffer plus inflight would exceed 2.
- Zero and full length: length 0 -> done in cycle 1, no mem_read_en, no m_valid. Length 32 -> all 32 words in order, done once.
- Start while busy: second start mid-burst with different base -> ignored, original sequence intact. Start in the done cycle -> accepted, first read at the new base one cycle later.
- Reset mid-burst: assert rst after 2 beats of an 8-word burst -> all outputs 0 immediately. After release, a new burst from base 0, length 2 delivers exactly mem[0], mem[1].
